esdi_serial_cmd: RTL and testbench

Host-side ESDI serial command/status engine. Accepts a 16-bit command word from the SoC register interface and shifts it to the drive over COMMAND DATA with the TRANSFER REQ/ACK bit handshake, appending odd parity. It then reads back 0..MAX_RESP 17-bit configuration/status words on CONFIG/STATUS DATA and reports parity and timeout errors. It sits between the SoC bus-register block and the ESDI pins, and is the parametrised successor to the fixed-wiring pin bridge.

---
 rtl/esdi_pkg.sv | 23 ++
 rtl/esdi_sync.sv | 24 ++
 rtl/esdi_serial_cmd.sv | 196 +++++++++++++++++++
 tb/tb_esdi_serial_cmd.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esdi_pkg.sv
// Shared types and helpers for the ESDI serial command/status engine.
// The frame on the wire is always a data word followed by one odd-parity bit.
package esdi_pkg;

    localparam int DEF_WORD_W  = 16;
    localparam int DEF_FRAME_W = DEF_WORD_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        C_SETUP,
        C_REQ,
        C_REL,
        R_REQ,
        R_REL,
        FINISH
    } esdi_state_e;

    // Bit that makes the total number of ones odd; callers zero-extend narrower words.
    function automatic logic odd_parity(input logic [63:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/esdi_sync.sv
// Multi-flop synchroniser for one asynchronous drive input.
// The output becomes valid STAGES clk edges after the input settles.
module esdi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/esdi_serial_cmd.sv
// Host-side ESDI serial command/status engine: shifts a command frame out over
// COMMAND DATA with the TRANSFER REQ/ACK handshake, then reads back status frames.
module esdi_serial_cmd
    import esdi_pkg::*;
#(
    parameter int WORD_W         = DEF_WORD_W,
    parameter int MAX_RESP       = 4,
    parameter int SETUP_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2,
    localparam int RN_W          = $clog2(MAX_RESP + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_word,
    input  logic [RN_W-1:0]   cmd_resp_n,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_word,
    output logic              resp_parity_err,
    output logic              done,
    output logic              err_timeout,
    output logic              attention,
    output logic              cmd_complete,
    output logic              esdi_transfer_req,
    output logic              esdi_command_data,
    input  logic              esdi_transfer_ack,
    input  logic              esdi_confstat_data,
    input  logic              esdi_command_complete,
    input  logic              esdi_attention
);

    localparam int FRAME_W = WORD_W + 1;
    localparam int BC_W    = $clog2(FRAME_W + 1);
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + SETUP_CYCLES + 1);

    logic [3:0] async_in;
    logic [3:0] sync_out;
    logic       ack_s;
    logic       conf_s;

    assign async_in = {esdi_attention, esdi_command_complete, esdi_confstat_data, esdi_transfer_ack};

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_sync
        esdi_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .resetn (resetn),
            .d      (async_in[gi]),
            .q      (sync_out[gi])
        );
    end

    assign ack_s        = sync_out[0];
    assign conf_s       = sync_out[1];
    assign cmd_complete = sync_out[2];
    assign attention    = sync_out[3];

    esdi_state_e        state_reg, state_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [BC_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [RN_W-1:0]    resp_n_reg, resp_n_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               tmo_reg, tmo_next;
    logic               resp_valid_reg, resp_valid_next;
    logic [WORD_W-1:0]  resp_word_reg, resp_word_next;
    logic               resp_err_reg, resp_err_next;
    logic               req_reg, req_next;
    logic               cdata_reg, cdata_next;
    logic               expired;

    assign expired = (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        resp_n_next     = resp_n_reg;
        tmo_next        = tmo_reg;
        resp_valid_next = 1'b0;
        resp_word_next  = resp_word_reg;
        resp_err_next   = resp_err_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    shift_next   = {cmd_word, odd_parity(64'(cmd_word))};
                    resp_n_next  = (cmd_resp_n > RN_W'(MAX_RESP)) ? RN_W'(MAX_RESP) : cmd_resp_n;
                    bit_cnt_next = BC_W'(FRAME_W);
                    tmo_next     = 1'b0;
                    state_next   = C_SETUP;
                end
            end
            C_SETUP: begin
                if (timer_reg == TMR_W'(SETUP_CYCLES - 1)) state_next = C_REQ;
            end
            C_REQ: begin
                if (ack_s) begin
                    state_next = C_REL;
                end else if (expired) begin
                    tmo_next   = 1'b1;
                    state_next = FINISH;
                end
            end
            C_REL: begin
                if (!ack_s) begin
                    shift_next   = shift_reg << 1;
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                    if (bit_cnt_reg == BC_W'(1)) begin
                        bit_cnt_next = BC_W'(FRAME_W);
                        state_next   = (resp_n_reg != '0) ? R_REQ : FINISH;
                    end else begin
                        state_next = C_SETUP;
                    end
                end else if (expired) begin
                    tmo_next   = 1'b1;
                    state_next = FINISH;
                end
            end
            R_REQ: begin
                // Data is sampled on the ack cycle; it passed the same sync depth as ack.
                if (ack_s) begin
                    shift_next   = {shift_reg[FRAME_W-2:0], conf_s};
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                    state_next   = R_REL;
                end else if (expired) begin
                    tmo_next   = 1'b1;
                    state_next = FINISH;
                end
            end
            R_REL: begin
                if (!ack_s) begin
                    if (bit_cnt_reg == '0) begin
                        resp_valid_next = 1'b1;
                        resp_word_next  = shift_reg[FRAME_W-1:1];
                        resp_err_next   = ((^shift_reg) != 1'b1);
                        resp_n_next     = resp_n_reg - 1'b1;
                        bit_cnt_next    = BC_W'(FRAME_W);
                        state_next      = (resp_n_reg == RN_W'(1)) ? FINISH : R_REQ;
                    end else begin
                        state_next = R_REQ;
                    end
                end else if (expired) begin
                    tmo_next   = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        timer_next = (state_next != state_reg || state_reg == IDLE) ? '0 : timer_reg + 1'b1;
        // Pin drivers are registered from the next state so they never glitch.
        req_next   = (state_next == C_REQ) || (state_next == R_REQ);
        cdata_next = (state_next == C_SETUP || state_next == C_REQ || state_next == C_REL)
                     ? shift_next[FRAME_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            resp_n_reg     <= '0;
            timer_reg      <= '0;
            tmo_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_word_reg  <= '0;
            resp_err_reg   <= 1'b0;
            req_reg        <= 1'b0;
            cdata_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            resp_n_reg     <= resp_n_next;
            timer_reg      <= timer_next;
            tmo_reg        <= tmo_next;
            resp_valid_reg <= resp_valid_next;
            resp_word_reg  <= resp_word_next;
            resp_err_reg   <= resp_err_next;
            req_reg        <= req_next;
            cdata_reg      <= cdata_next;
        end
    end

    assign cmd_ready         = (state_reg == IDLE);
    assign done              = (state_reg == FINISH);
    assign err_timeout       = done & tmo_reg;
    assign resp_valid        = resp_valid_reg;
    assign resp_word         = resp_word_reg;
    assign resp_parity_err   = resp_err_reg;
    assign esdi_transfer_req = req_reg;
    assign esdi_command_data = cdata_reg;

endmodule

// File: tb/tb_esdi_serial_cmd.sv
// Directed bench for esdi_serial_cmd: a drive model acks 3 cycles after each
// req edge, captures command bits and plays back response frames.
module tb_esdi_serial_cmd;

    localparam int SETUP = 8;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_word = '0;
    logic [2:0]  cmd_resp_n = '0;
    logic        cmd_ready, resp_valid, resp_parity_err, done, err_timeout;
    logic [15:0] resp_word;
    logic        attention, cmd_complete, esdi_transfer_req, esdi_command_data;
    logic        ack = 1'b0;
    logic        conf = 1'b0;
    logic        esdi_command_complete = 1'b0;
    logic        esdi_attention = 1'b0;

    always #5 clk = ~clk;

    esdi_serial_cmd #(
        .WORD_W(16), .MAX_RESP(4), .SETUP_CYCLES(SETUP),
        .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_word(cmd_word), .cmd_resp_n(cmd_resp_n), .resp_valid(resp_valid),
        .resp_word(resp_word), .resp_parity_err(resp_parity_err), .done(done),
        .err_timeout(err_timeout), .attention(attention), .cmd_complete(cmd_complete),
        .esdi_transfer_req(esdi_transfer_req), .esdi_command_data(esdi_command_data),
        .esdi_transfer_ack(ack), .esdi_confstat_data(conf),
        .esdi_command_complete(esdi_command_complete), .esdi_attention(esdi_attention)
    );

    int total = 0;
    int bad = 0;

    // Written only by the stimulus process.
    logic             model_clr = 1'b0;
    logic             drive_en = 1'b1;
    logic [3:0][16:0] resp_frames = '0;

    // Drive model state.
    int          cmd_bits, all_reqs, setup_viol, ridx, fidx, dly, stable;
    logic [16:0] cmd_cap;
    logic        req_seen, cd_prev;

    always @(negedge clk) begin
        if (model_clr) begin
            cmd_bits = 0; all_reqs = 0; setup_viol = 0; ridx = 0; fidx = 0;
            dly = 0; stable = 0; cmd_cap = '0; req_seen = 1'b0; cd_prev = 1'b0;
            ack = 1'b0; conf = 1'b0;
        end else begin
            if (esdi_command_data == cd_prev) stable++; else stable = 1;
            cd_prev = esdi_command_data;
            if (esdi_transfer_req != req_seen) begin
                req_seen = esdi_transfer_req;
                dly = 3;
                if (req_seen) begin
                    all_reqs++;
                    if (cmd_bits < 17) begin
                        cmd_cap = {cmd_cap[15:0], esdi_command_data};
                        if (stable - 1 < SETUP) setup_viol++;
                        cmd_bits++;
                    end else begin
                        conf = (fidx < 4) ? resp_frames[fidx][16-ridx] : 1'b0;
                        ridx++;
                        if (ridx == 17) begin ridx = 0; fidx++; end
                    end
                end
            end else if (dly > 0) begin
                dly--;
                if (dly == 0 && drive_en) ack = req_seen;
            end
        end
    end

    // Output monitor.
    int               done_cnt, nresp, req_len;
    logic             tmo_seen, ready_after, ready_pending, req_was;
    logic [3:0][15:0] rw;
    logic [3:0]       re;

    always @(negedge clk) begin
        if (model_clr) begin
            done_cnt = 0; nresp = 0; req_len = 0; tmo_seen = 1'b0;
            ready_after = 1'b0; ready_pending = 1'b0; req_was = 1'b0; rw = '0; re = '0;
        end else begin
            if (ready_pending) begin ready_after = cmd_ready; ready_pending = 1'b0; end
            if (done) begin done_cnt++; tmo_seen = err_timeout; ready_pending = 1'b1; end
            if (resp_valid) begin
                if (nresp < 4) begin rw[nresp] = resp_word; re[nresp] = resp_parity_err; end
                nresp++;
            end
            if (esdi_transfer_req) begin
                if (!req_was) req_len = 0;
                req_len++;
            end
            req_was = esdi_transfer_req;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0]      cmd;
        logic [2:0]       rn;
        logic             ack_en;
        logic [3:0][16:0] fr;
        logic [16:0]      exp_frame;
        logic [2:0]       exp_nresp;
        logic             exp_tmo;
        logic [3:0]       exp_err;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mkv(input logic [15:0] c, input logic [2:0] rn, input logic a,
                                 input logic [16:0] f0, input logic [16:0] f1,
                                 input logic [16:0] f2, input logic [16:0] f3,
                                 input logic [16:0] ef, input logic [2:0] nr,
                                 input logic t, input logic [3:0] ee);
        vec_t v;
        v.cmd = c; v.rn = rn; v.ack_en = a; v.fr = {f3, f2, f1, f0};
        v.exp_frame = ef; v.exp_nresp = nr; v.exp_tmo = t; v.exp_err = ee;
        return v;
    endfunction

    task automatic start_cmd(input logic [15:0] w, input logic [2:0] rn);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        @(posedge clk); model_clr = 1'b1;
        @(posedge clk); model_clr = 1'b0;
        @(negedge clk); cmd_valid = 1'b1; cmd_word = w; cmd_resp_n = rn;
        @(negedge clk); cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 5000) begin @(posedge clk); n++; end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (30) @(posedge clk);
    endtask

    task automatic run_vec(input int i);
        vec_t v = vecs[i];
        drive_en = v.ack_en;
        resp_frames = v.fr;
        start_cmd(v.cmd, v.rn);
        wait_done();
        $display("vec %0d: cmd=%h rn=%0d bits=%0d frame=%h done=%0d tmo=%0d nresp=%0d",
                 i, v.cmd, v.rn, cmd_bits, cmd_cap, done_cnt, tmo_seen, nresp);
        chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d_tmo", i), 32'(tmo_seen), 32'(v.exp_tmo));
        chk($sformatf("v%0d_ready_after", i), 32'(ready_after), 32'd1);
        chk($sformatf("v%0d_cmd_bits", i), 32'(cmd_bits), v.exp_tmo ? 32'd1 : 32'd17);
        chk($sformatf("v%0d_setup_viol", i), 32'(setup_viol), 32'd0);
        chk($sformatf("v%0d_nresp", i), 32'(nresp), 32'(v.exp_nresp));
        if (!v.exp_tmo) chk($sformatf("v%0d_frame", i), 32'(cmd_cap), 32'(v.exp_frame));
        else            chk($sformatf("v%0d_req_len", i), 32'(req_len), 32'(TMO));
        for (int k = 0; k < 4; k++) begin
            if (k < int'(v.exp_nresp)) begin
                chk($sformatf("v%0d_word%0d", i, k), 32'(rw[k]), 32'(v.fr[k][16:1]));
                chk($sformatf("v%0d_perr%0d", i, k), 32'(re[k]), 32'(v.exp_err[k]));
            end
        end
        drive_en = 1'b1;
    endtask

    initial begin
        vecs[0] = mkv(16'h1234, 3'd0, 1'b1, 17'h0, 17'h0, 17'h0, 17'h0,
                      17'h02468, 3'd0, 1'b0, 4'b0000);
        vecs[1] = mkv(16'h0000, 3'd2, 1'b1, 17'h14B4B, 17'h1FFFE, 17'h0, 17'h0,
                      17'h00001, 3'd2, 1'b0, 4'b0010);
        vecs[2] = mkv(16'h8001, 3'd7, 1'b1, 17'h00002, 17'h00006, 17'h10001, 17'h02468,
                      17'h10003, 3'd4, 1'b0, 4'b0110);
        vecs[3] = mkv(16'hFFFF, 3'd1, 1'b0, 17'h0, 17'h0, 17'h0, 17'h0,
                      17'h0, 3'd0, 1'b1, 4'b0000);
        vecs[4] = mkv(16'h7FFE, 3'd1, 1'b1, 17'h01E1F, 17'h0, 17'h0, 17'h0,
                      17'h0FFFD, 3'd1, 1'b0, 4'b0000);

        model_clr = 1'b1;
        repeat (3) @(posedge clk);
        model_clr = 1'b0;
        @(negedge clk);
        $display("reset: ready=%0d done=%0d req=%0d", cmd_ready, done, esdi_transfer_req);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(esdi_transfer_req), 32'd0);
        chk("rst_cdata", 32'(esdi_command_data), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset during the 5th command bit, then a clean command.
        begin
            int n = 0;
            start_cmd(16'h1234, 3'd0);
            while (cmd_bits < 5 && n < 2000) begin @(posedge clk); n++; end
            chk("midrst_reached_bit5", 32'(cmd_bits), 32'd5);
            @(negedge clk); resetn = 1'b0;
            @(negedge clk);
            $display("midreset: req=%0d ready=%0d", esdi_transfer_req, cmd_ready);
            chk("midrst_req", 32'(esdi_transfer_req), 32'd0);
            chk("midrst_ready", 32'(cmd_ready), 32'd1);
            repeat (2) @(negedge clk);
            resetn = 1'b1;
            repeat (20) @(posedge clk);
            chk("midrst_no_done", 32'(done_cnt), 32'd0);
            chk("midrst_no_resp", 32'(nresp), 32'd0);
            run_vec(0);
        end

        // cmd_valid while busy must be ignored.
        start_cmd(16'h1234, 3'd0);
        repeat (20) @(negedge clk);
        cmd_valid = 1'b1; cmd_word = 16'hFFFF; cmd_resp_n = 3'd0;
        @(negedge clk); cmd_valid = 1'b0;
        wait_done();
        repeat (600) @(posedge clk);
        $display("busy: done_cnt=%0d reqs=%0d frame=%h", done_cnt, all_reqs, cmd_cap);
        chk("busy_done_cnt", 32'(done_cnt), 32'd1);
        chk("busy_all_reqs", 32'(all_reqs), 32'd17);
        chk("busy_frame", 32'(cmd_cap), 32'h02468);

        // Pass-through synchronisers: two-edge latency.
        @(negedge clk); esdi_attention = 1'b1; esdi_command_complete = 1'b1;
        @(negedge clk);
        chk("attn_lat1", 32'(attention), 32'd0);
        chk("cc_lat1", 32'(cmd_complete), 32'd0);
        @(negedge clk);
        $display("sync: attention=%0d cmd_complete=%0d", attention, cmd_complete);
        chk("attn_lat2", 32'(attention), 32'd1);
        chk("cc_lat2", 32'(cmd_complete), 32'd1);
        esdi_attention = 1'b0;
        repeat (2) @(negedge clk);
        chk("attn_fall", 32'(attention), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
